// File: rtl/ramb4_loader_pkg.sv
// Shared types and constants for the iCE40 nibble BRAM loader.
// Mode-2 (1024x4) places nibble bits 0..3 on data lanes 1, 5, 9 and 13.
package ramb4_loader_pkg;

  localparam int ADDR_W = 32'sd10;
  localparam int DEPTH  = 32'sd1024;

  localparam int LANE_B0 = 32'sd1;
  localparam int LANE_B1 = 32'sd5;
  localparam int LANE_B2 = 32'sd9;
  localparam int LANE_B3 = 32'sd13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/ramb4_core.sv
// Wraps one SB_RAM40_4K as a 1024x4 RAM with plain nibble write/read ports.
module ramb4_core
  import ramb4_loader_pkg::*;
#(
  parameter logic [3:0] INIT_NIBBLE = 4'h0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [3:0]        q
);

  localparam logic [255:0] INIT_WORD = {64{INIT_NIBBLE}};

  logic [15:0] wdata_pk_s;
  logic [15:0] rdata_s;
  logic        unused_rdata_s;

  // Spread the write nibble onto the mode-2 data lanes.
  always_comb begin
    wdata_pk_s          = 16'h0000;
    wdata_pk_s[LANE_B0] = wdata[0];
    wdata_pk_s[LANE_B1] = wdata[1];
    wdata_pk_s[LANE_B2] = wdata[2];
    wdata_pk_s[LANE_B3] = wdata[3];
  end

  assign q = {rdata_s[LANE_B3], rdata_s[LANE_B2], rdata_s[LANE_B1], rdata_s[LANE_B0]};
  assign unused_rdata_s = ^rdata_s;

  SB_RAM40_4K #(
    .READ_MODE (32'sd2),
    .WRITE_MODE(32'sd2),
    .INIT_0(INIT_WORD), .INIT_1(INIT_WORD), .INIT_2(INIT_WORD), .INIT_3(INIT_WORD),
    .INIT_4(INIT_WORD), .INIT_5(INIT_WORD), .INIT_6(INIT_WORD), .INIT_7(INIT_WORD),
    .INIT_8(INIT_WORD), .INIT_9(INIT_WORD), .INIT_A(INIT_WORD), .INIT_B(INIT_WORD),
    .INIT_C(INIT_WORD), .INIT_D(INIT_WORD), .INIT_E(INIT_WORD), .INIT_F(INIT_WORD)
  ) u_bram (
    .RDATA(rdata_s),
    .RADDR({1'b0, raddr}),
    .RCLK (clk),
    .RCLKE(1'b1),
    .RE   (1'b1),
    .WADDR({1'b0, waddr}),
    .WCLK (clk),
    .WCLKE(we),
    .WDATA(wdata_pk_s),
    .WE   (we),
    .MASK (16'h0000)
  );

endmodule

// File: rtl/sb_ram40_4k.sv
// Behavioural stand-in for the iCE40 SB_RAM40_4K block, covering the 1024x4 mode.
// INIT words are laid out as one 4096-bit image, nibble a at bits [4a+3:4a].
module SB_RAM40_4K #(
  parameter int          READ_MODE  = 32'sd0,
  parameter int          WRITE_MODE = 32'sd0,
  parameter logic [255:0] INIT_0 = 256'h0, parameter logic [255:0] INIT_1 = 256'h0,
  parameter logic [255:0] INIT_2 = 256'h0, parameter logic [255:0] INIT_3 = 256'h0,
  parameter logic [255:0] INIT_4 = 256'h0, parameter logic [255:0] INIT_5 = 256'h0,
  parameter logic [255:0] INIT_6 = 256'h0, parameter logic [255:0] INIT_7 = 256'h0,
  parameter logic [255:0] INIT_8 = 256'h0, parameter logic [255:0] INIT_9 = 256'h0,
  parameter logic [255:0] INIT_A = 256'h0, parameter logic [255:0] INIT_B = 256'h0,
  parameter logic [255:0] INIT_C = 256'h0, parameter logic [255:0] INIT_D = 256'h0,
  parameter logic [255:0] INIT_E = 256'h0, parameter logic [255:0] INIT_F = 256'h0
) (
  output logic [15:0] RDATA,
  input  logic [10:0] RADDR,
  input  logic        RCLK,
  input  logic        RCLKE,
  input  logic        RE,
  input  logic [10:0] WADDR,
  input  logic        WCLK,
  input  logic        WCLKE,
  input  logic [15:0] WDATA,
  input  logic        WE,
  input  logic [15:0] MASK
);

  logic [4095:0] mem_r = {INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
                          INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};
  logic [15:0]   rdata_r;
  logic [3:0]    rd_nib_s;
  logic          unused_s;

  assign rd_nib_s = mem_r[{RADDR[9:0], 2'b00} +: 4];
  assign unused_s = ^{WDATA, MASK, RADDR[10], WADDR[10]};
  assign RDATA    = rdata_r;

  // Write port: one nibble per enabled write clock edge.
  always_ff @(posedge WCLK) begin
    if (WE && WCLKE && (WRITE_MODE == 32'sd2)) begin
      mem_r[{WADDR[9:0], 2'b00} +: 4] <= {WDATA[13], WDATA[9], WDATA[5], WDATA[1]};
    end
  end

  // Read port: registered output, nibble spread back onto lanes 13/9/5/1.
  always_ff @(posedge RCLK) begin
    if (RE && RCLKE) begin
      if (READ_MODE == 32'sd2) begin
        rdata_r <= {2'b00, rd_nib_s[3], 3'b000, rd_nib_s[2], 3'b000,
                    rd_nib_s[1], 3'b000, rd_nib_s[0], 1'b0};
      end else begin
        rdata_r <= 16'h0000;
      end
    end
  end

endmodule

// File: rtl/ramb4_loader.sv
// Streams nibbles into a 1024x4 BRAM region, then reads the region back and
// checks an 8-bit modular sum. The read port is the consumer's outside verify.
module ramb4_loader
  import ramb4_loader_pkg::*;
#(
  parameter logic [3:0] INIT_NIBBLE = 4'h0
) (
  input  logic              CLKIN,
  input  logic              RESETN,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  input  logic [3:0]        D,
  input  logic              DVALID,
  output logic              DREADY,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [3:0]        Q,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        CSUM
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  state_t              state_r, state_n;
  logic [ADDR_W-1:0]   base_r;
  logic [ADDR_W:0]     len_r, len_clamp_s;
  logic [ADDR_W:0]     cnt_r;
  logic [7:0]          csum_r, rsum_r, rsum_n_s;
  logic                err_r, done_r, busy_r, dready_r;
  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r, raddr_s, offs_addr_s;
  logic [3:0]          wdata_r;
  logic                accept_s, last_beat_s, verify_last_s;

  assign accept_s      = (state_r == ST_LOAD) && DVALID && dready_r;
  assign last_beat_s   = accept_s && (cnt_r == (len_r - 11'd1));
  assign verify_last_s = (cnt_r == len_r);
  assign offs_addr_s   = base_r + cnt_r[ADDR_W-1:0];
  assign rsum_n_s      = rsum_r + {4'h0, Q};

  // Clamp requested length to the RAM depth.
  always_comb begin
    if (LEN > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = LEN;
    end
  end

  // Verify owns the read port; otherwise the consumer address goes through.
  always_comb begin
    if (state_r == ST_VERIFY) begin
      raddr_s = offs_addr_s;
    end else begin
      raddr_s = RADDR;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          if (len_clamp_s == 11'd0) state_n = ST_FIN;
          else                      state_n = ST_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_beat_s) state_n = ST_DRAIN;
        else             state_n = ST_LOAD;
      end
      ST_DRAIN:  state_n = ST_VERIFY;
      ST_VERIFY: begin
        if (verify_last_s) state_n = ST_FIN;
        else               state_n = ST_VERIFY;
      end
      ST_FIN:    state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // State register, status flags and the registered write port.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      dready_r <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      waddr_r  <= '0;
      wdata_r  <= 4'h0;
    end else begin
      state_r  <= state_n;
      busy_r   <= (state_n == ST_LOAD) || (state_n == ST_DRAIN) || (state_n == ST_VERIFY);
      dready_r <= (state_n == ST_LOAD);
      done_r   <= (state_n == ST_FIN);
      we_r     <= accept_s;
      if (accept_s) begin
        waddr_r <= offs_addr_s;
        wdata_r <= D;
      end
    end
  end

  // Counters and checksums; cnt_r counts beats in LOAD, then reads in VERIFY.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      base_r <= '0;
      len_r  <= '0;
      cnt_r  <= '0;
      csum_r <= 8'h00;
      rsum_r <= 8'h00;
      err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            base_r <= BASE;
            len_r  <= len_clamp_s;
            cnt_r  <= '0;
            csum_r <= 8'h00;
            err_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            csum_r <= csum_r + {4'h0, D};
            cnt_r  <= cnt_r + 11'd1;
          end
        end
        ST_DRAIN: begin
          cnt_r  <= '0;
          rsum_r <= 8'h00;
        end
        ST_VERIFY: begin
          cnt_r <= cnt_r + 11'd1;
          // Data for read cnt_r-1 arrives this cycle.
          if (cnt_r != 11'd0) rsum_r <= rsum_n_s;
          if (verify_last_s)  err_r  <= (rsum_n_s != csum_r);
        end
        default: begin
        end
      endcase
    end
  end

  assign DREADY = dready_r;
  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign ERR    = err_r;
  assign CSUM   = csum_r;

  ramb4_core #(.INIT_NIBBLE(INIT_NIBBLE)) u_core (
    .clk  (CLKIN),
    .we   (we_r),
    .waddr(waddr_r),
    .wdata(wdata_r),
    .raddr(raddr_s),
    .q    (Q)
  );

endmodule

// File: tb/tb_ramb4_loader.sv
// Directed self-checking bench for ramb4_loader.
module tb_ramb4_loader;

  logic       CLKIN = 1'b0;
  logic       RESETN, START, DVALID;
  logic [9:0] BASE, RADDR;
  logic [10:0] LEN;
  logic [3:0] D, Q;
  logic       DREADY, BUSY, DONE, ERR;
  logic [7:0] CSUM;

  int checks = 0;
  int errors = 0;

  always #5 CLKIN = ~CLKIN;

  ramb4_loader #(.INIT_NIBBLE(4'h0)) dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .START(START), .BASE(BASE), .LEN(LEN),
    .D(D), .DVALID(DVALID), .DREADY(DREADY), .RADDR(RADDR), .Q(Q),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
  );

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic start_load(input logic [9:0] b, input logic [10:0] l);
    BASE = b; LEN = l; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (DONE !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic read_q(input logic [9:0] a, output logic [3:0] q);
    RADDR = a;
    tick();
    q = Q;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; START = 1'b0; DVALID = 1'b0; D = 4'h0; BASE = 10'd0; LEN = 11'd0; RADDR = 10'd0;
    #12;
    checks++; if (DREADY !== 1'b0) begin errors++; $display("FAIL reset_dready: got %b expected 0", DREADY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
    checks++; if (CSUM !== 8'h00) begin errors++; $display("FAIL reset_csum: got %h expected 00", CSUM); end
    tick();
    RESETN = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int n;
    logic [3:0] q;
    logic [9:0] addrs [9] = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
    start_load(10'd1020, 11'd8);
    checks++; if (BUSY !== 1'b1 || DREADY !== 1'b1) begin errors++; $display("FAIL wrap_busy_ready: got %b%b expected 11", BUSY, DREADY); end
    DVALID = 1'b1; D = 4'hA;
    for (int i = 0; i < 8; i++) tick();
    DVALID = 1'b0;
    wait_done(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL wrap_done_time: got %0d expected 10", n); end
    checks++; if (CSUM !== 8'h50) begin errors++; $display("FAIL wrap_csum: got %h expected 50", CSUM); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", ERR); end
    tick();
    for (int i = 0; i < 9; i++) begin
      read_q(addrs[i], q);
      checks++;
      if (q !== ((i < 8) ? 4'hA : 4'h0)) begin
        errors++; $display("FAIL wrap_mem[%0d]: got %h expected %h", addrs[i], q, (i < 8) ? 4'hA : 4'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] q;
    start_load(10'd0, 11'd16);
    DVALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      D = 4'(i);
      tick();
    end
    DVALID = 1'b0;
    wait_done(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL b2b_done_time: got %0d expected 18", n); end
    checks++; if (CSUM !== 8'h78) begin errors++; $display("FAIL b2b_csum: got %h expected 78", CSUM); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", ERR); end
    tick();
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got done=%b busy=%b expected 0 0", DONE, BUSY); end
    read_q(10'd5, q);
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL b2b_readback: got %h expected 5", q); end
  endtask

  task automatic test_gaps();
    int n;
    int wr = 0;
    logic [3:0] q;
    start_load(10'd200, 11'd4);
    for (int i = 0; i < 7; i++) begin
      DVALID = (i % 2 == 0);
      D = (i % 2 == 0) ? 4'(i / 2 + 1) : 4'hF;
      checks++; if (DREADY !== 1'b1) begin errors++; $display("FAIL gaps_dready[%0d]: got %b expected 1", i, DREADY); end
      tick();
      if (dut.we_r === 1'b1) wr++;
    end
    DVALID = 1'b0;
    checks++; if (wr !== 4) begin errors++; $display("FAIL gaps_write_count: got %0d expected 4", wr); end
    wait_done(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL gaps_done_time: got %0d expected 6", n); end
    checks++; if (CSUM !== 8'h0A) begin errors++; $display("FAIL gaps_csum: got %h expected 0a", CSUM); end
    tick();
    for (int i = 0; i < 5; i++) begin
      read_q(10'(200 + i), q);
      checks++;
      if (q !== ((i < 4) ? 4'(i + 1) : 4'h0)) begin
        errors++; $display("FAIL gaps_mem[%0d]: got %h expected %h", 200 + i, q, (i < 4) ? 4'(i + 1) : 4'h0);
      end
    end
  endtask

  task automatic test_len0_and_start_ignored();
    int n;
    logic [3:0] q;
    DVALID = 1'b1; D = 4'h7;
    start_load(10'd300, 11'd0);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || DREADY !== 1'b0) begin errors++; $display("FAIL len0_flags: got done=%b busy=%b dready=%b expected 1 0 0", DONE, BUSY, DREADY); end
    checks++; if (CSUM !== 8'h00 || ERR !== 1'b0) begin errors++; $display("FAIL len0_csum_err: got %h %b expected 00 0", CSUM, ERR); end
    checks++; if (dut.we_r !== 1'b0) begin errors++; $display("FAIL len0_no_write: got %b expected 0", dut.we_r); end
    DVALID = 1'b0;
    tick();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL len0_done_pulse: got %b expected 0", DONE); end
    read_q(10'd300, q);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL len0_mem: got %h expected 0", q); end

    start_load(10'd400, 11'd4);
    DVALID = 1'b1; D = 4'h1;
    tick();
    D = 4'h2; BASE = 10'd500; LEN = 11'd2; START = 1'b1;
    tick();
    START = 1'b0; D = 4'h3;
    tick();
    D = 4'h4;
    tick();
    DVALID = 1'b0;
    wait_done(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL ign_done_time: got %0d expected 6", n); end
    checks++; if (CSUM !== 8'h0A) begin errors++; $display("FAIL ign_csum: got %h expected 0a", CSUM); end
    tick();
    read_q(10'd500, q);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL ign_mem500: got %h expected 0", q); end
    read_q(10'd403, q);
    checks++; if (q !== 4'h4) begin errors++; $display("FAIL ign_mem403: got %h expected 4", q); end
  endtask

  task automatic test_corrupt();
    int n;
    start_load(10'd600, 11'd8);
    DVALID = 1'b1; D = 4'h3;
    for (int i = 0; i < 8; i++) tick();
    DVALID = 1'b0;
    tick();
    dut.u_core.u_bram.mem_r[2431:2428] = 4'h0;
    wait_done(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL corrupt_done_time: got %0d expected 9", n); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL corrupt_err: got %b expected 1", ERR); end
    checks++; if (CSUM !== 8'h18) begin errors++; $display("FAIL corrupt_csum: got %h expected 18", CSUM); end
    tick(); tick(); tick();
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL corrupt_err_sticky: got %b expected 1", ERR); end
    start_load(10'd0, 11'd0);
    checks++; if (ERR !== 1'b0 || DONE !== 1'b1) begin errors++; $display("FAIL corrupt_err_clear: got err=%b done=%b expected 0 1", ERR, DONE); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    int n;
    logic [3:0] q;
    start_load(10'd700, 11'd8);
    DVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 4'(i + 1);
      tick();
    end
    DVALID = 1'b0;
    tick();
    #2 RESETN = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0 || DREADY !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b dready=%b expected 0 0", BUSY, DREADY); end
    tick();
    RESETN = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      read_q(10'(700 + i), q);
      checks++;
      if (q !== ((i < 3) ? 4'(i + 1) : 4'h0)) begin
        errors++; $display("FAIL rstmid_mem[%0d]: got %h expected %h", 700 + i, q, (i < 3) ? 4'(i + 1) : 4'h0);
      end
    end
    start_load(10'd700, 11'd2);
    DVALID = 1'b1; D = 4'h5;
    tick();
    D = 4'h6;
    tick();
    DVALID = 1'b0;
    wait_done(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rstmid_reload_time: got %0d expected 4", n); end
    checks++; if (CSUM !== 8'h0B || ERR !== 1'b0) begin errors++; $display("FAIL rstmid_reload_csum: got %h err=%b expected 0b 0", CSUM, ERR); end
    tick();
    read_q(10'd701, q);
    checks++; if (q !== 4'h6) begin errors++; $display("FAIL rstmid_reload_mem: got %h expected 6", q); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_back_to_back();
    test_gaps();
    test_len0_and_start_ignored();
    test_corrupt();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
